versatile_fifo_mc_ctrl: RTL and testbench
=========================================

# versatile_fifo_mc_ctrl

Single-clock, multi-channel FIFO pointer and status controller. It manages NR_OF_CH independent circular queues that share one dual-port RAM, and produces the RAM write/read addresses and enables. It also provides per-channel full, empty, almost-full and almost-empty flags, sticky overflow/underflow errors, per-channel flush and a fill-level readout. It replaces the async quadrant comparator wherever both FIFO sides run on one clock and more than one queue is needed.

## Interface
- ADDR_WIDTH, 4: per-channel address bits; depth D = 2^ADDR_WIDTH.
- NR_OF_CH, 4: number of channels.
- CH_WIDTH, 2: channel index width; NR_OF_CH <= 2^CH_WIDTH.
- AFULL_LEVEL, 12: almost_full asserted when count >= AFULL_LEVEL.
- AEMPTY_LEVEL, 2: almost_empty asserted when count <= AEMPTY_LEVEL.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write request.
- wr_ch  in  CH_WIDTH  channel addressed by the write.
- rd_en  in  1  read request.
- rd_ch  in  CH_WIDTH  channel addressed by the read.
- clr  in  NR_OF_CH  per-channel synchronous flush.
- stat_ch  in  CH_WIDTH  channel shown on fill_level.
- mem_we  out  1  RAM write enable (accepted write).
- waddr  out  CH_WIDTH+ADDR_WIDTH  {wr_ch, wptr[wr_ch] low bits}.
- mem_re  out  1  RAM read enable (accepted read).
- raddr  out  CH_WIDTH+ADDR_WIDTH  {rd_ch, rptr[rd_ch] low bits}.
- fifo_full, fifo_empty, almost_full, almost_empty  out  NR_OF_CH each  per-channel status.
- overflow, underflow  out  NR_OF_CH each  sticky error flags.
- fill_level  out  ADDR_WIDTH+1  occupancy of stat_ch, range 0..D.

## Operation
- Each channel holds a binary wptr and rptr of ADDR_WIDTH+1 bits. The MSB is the wrap bit, and both pointers wrap modulo 2^(ADDR_WIDTH+1).
- count = (wptr - rptr) mod 2^(ADDR_WIDTH+1).
- Flags: full = (count == D), empty = (count == 0), almost_full = (count >= AFULL_LEVEL), almost_empty = (count <= AEMPTY_LEVEL).
- Write acceptance: a write is accepted when wr_en=1, full[wr_ch]=0 and clr[wr_ch]=0. mem_we=1 and wptr[wr_ch] increments at the edge.
- Rejected write: when wr_en=1, full[wr_ch]=1 and clr[wr_ch]=0, overflow[wr_ch] is set and no pointer moves.
- Read acceptance: a read is accepted when rd_en=1, empty[rd_ch]=0 and clr[rd_ch]=0. mem_re=1 and rptr[rd_ch] increments.
- Rejected read: when rd_en=1, empty[rd_ch]=1 and clr[rd_ch]=0, underflow[rd_ch] is set.
- Acceptance is decided on the pre-edge flags.
- Same-channel simultaneous read and write:
  - Full channel: the read is accepted, the write is rejected and overflow is set.
  - Empty channel: the write is accepted and the read is rejected with underflow set. There is no fall-through.
  - Otherwise both are accepted and count is unchanged.
- Different channels: a write and a read to different channels are fully independent.
- Flush: clr[c]=1 sets wptr[c]=rptr[c]=0 and clears overflow[c] and underflow[c]. Flush has priority over wr/rd to channel c in that cycle. Those operations are dropped with mem_we/mem_re=0 and no error set. Other channels are unaffected.
- Out-of-range channels: wr_ch/rd_ch values >= NR_OF_CH are ignored (no enable, no error).

## Timing
- waddr, raddr, mem_we and mem_re are combinational from the inputs and the current pointers. The RAM samples them at the same edge that advances the pointers.
- The RAM returns read data one cycle after mem_re (synchronous read). Data is not registered by this block.
- Status flags, errors and fill_level are registered state or decode of registered pointers. They reflect an accepted operation immediately after the clock edge that performs it (no extra lag).
- Reset (rst_n=0, asynchronous, mid-operation included) forces:
  - all pointers to 0;
  - fifo_empty and almost_empty to all ones;
  - fifo_full, almost_full, overflow and underflow to 0;
  - fill_level to 0.
- mem_we and mem_re are forced to 0 while rst_n=0. Deassertion takes effect at the next rising clk.

## Test plan
- Fill: reset, then 16 writes to channel 0 (D=16).
  - almost_full rises after the 12th write, full after the 16th, and fill_level=16.
  - almost_empty falls after the 3rd write.
  - waddr runs 0x00..0x0F.
- Overflow and flush: with channel 0 full, wr_en=1 for 1 cycle gives mem_we=0, overflow[0]=1 and pointers unchanged. clr[0] pulse then gives empty[0]=1 and overflow[0]=0.
- Wrap-around: 40 interleaved writes/reads on channel 2 keeping count at 5.
  - raddr wraps from 0x2F to 0x20.
  - Flags stay constant and fill_level stays 5.
- Simultaneous operations:
  - Same channel when full: the read is accepted, the write is rejected and count becomes 15.
  - Same channel when empty: the write is accepted, underflow is set and count becomes 1.
- Channel independence: write channel 1 while reading channel 3 (count 4) in the same cycle. Channel 1 count goes 0 to 1, channel 3 goes 4 to 3, and no errors.
- Reset mid-operation: assert rst_n=0 between edges while channels are partially filled. All outputs reach their reset values asynchronously, and the first write after release targets address {ch,0}.

Source files
------------

// File: rtl/versatile_fifo_mc_ctrl_if.sv
// Request/status bundle between a multi-channel FIFO controller and its user.
// The master drives the requests; the slave (controller) drives the RAM strobes and status.
interface versatile_fifo_mc_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int NR_OF_CH   = 4,
    parameter int CH_WIDTH   = 2
);
    logic                         wr_en;
    logic [CH_WIDTH-1:0]          wr_ch;
    logic                         rd_en;
    logic [CH_WIDTH-1:0]          rd_ch;
    logic [NR_OF_CH-1:0]          clr;
    logic [CH_WIDTH-1:0]          stat_ch;
    logic                         mem_we;
    logic [CH_WIDTH+ADDR_WIDTH-1:0] waddr;
    logic                         mem_re;
    logic [CH_WIDTH+ADDR_WIDTH-1:0] raddr;
    logic [NR_OF_CH-1:0]          fifo_full;
    logic [NR_OF_CH-1:0]          fifo_empty;
    logic [NR_OF_CH-1:0]          almost_full;
    logic [NR_OF_CH-1:0]          almost_empty;
    logic [NR_OF_CH-1:0]          overflow;
    logic [NR_OF_CH-1:0]          underflow;
    logic [ADDR_WIDTH:0]          fill_level;

    modport master (
        output wr_en, wr_ch, rd_en, rd_ch, clr, stat_ch,
        input  mem_we, waddr, mem_re, raddr, fifo_full, fifo_empty,
               almost_full, almost_empty, overflow, underflow, fill_level
    );

    modport slave (
        input  wr_en, wr_ch, rd_en, rd_ch, clr, stat_ch,
        output mem_we, waddr, mem_re, raddr, fifo_full, fifo_empty,
               almost_full, almost_empty, overflow, underflow, fill_level
    );
endinterface

// File: rtl/versatile_fifo_mc_ctrl.sv
// Single-clock pointer/status controller for NR_OF_CH circular queues sharing one
// dual-port RAM; each channel owns a 2^ADDR_WIDTH slice selected by the channel index.
module versatile_fifo_mc_ctrl #(
    parameter int ADDR_WIDTH   = 4,
    parameter int NR_OF_CH     = 4,
    parameter int CH_WIDTH     = 2,
    parameter int AFULL_LEVEL  = 12,
    parameter int AEMPTY_LEVEL = 2
) (
    input logic                    clk,
    input logic                    rst_n,
    versatile_fifo_mc_ctrl_if.slave bus
);
    typedef logic [ADDR_WIDTH:0] ptr_t;

    localparam ptr_t DEPTH      = ptr_t'(1) << ADDR_WIDTH;
    localparam ptr_t ONE        = ptr_t'(1);
    localparam ptr_t AFULL_CNT  = ptr_t'(AFULL_LEVEL);
    localparam ptr_t AEMPTY_CNT = ptr_t'(AEMPTY_LEVEL);

    ptr_t wptr [NR_OF_CH];
    ptr_t rptr [NR_OF_CH];
    ptr_t cnt  [NR_OF_CH];

    logic [NR_OF_CH-1:0]   full, empty, afull, aempty;
    logic [NR_OF_CH-1:0]   wr_acc, wr_rej, rd_acc, rd_rej;
    logic [NR_OF_CH-1:0]   ovf_q, udf_q;
    logic [ADDR_WIDTH-1:0] waddr_lo, raddr_lo;
    ptr_t                  fill;

    // Occupancy uses the wrap bit, so a full queue (count == DEPTH) is distinct from empty.
    for (genvar g = 0; g < NR_OF_CH; g++) begin : g_status
        assign cnt[g]    = wptr[g] - rptr[g];
        assign full[g]   = (cnt[g] == DEPTH);
        assign empty[g]  = (cnt[g] == '0);
        assign afull[g]  = (cnt[g] >= AFULL_CNT);
        assign aempty[g] = (cnt[g] <= AEMPTY_CNT);
    end

    // Channel indices with no matching c fall through every compare and are ignored.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wr_acc   = '0;
        wr_rej   = '0;
        rd_acc   = '0;
        rd_rej   = '0;
        waddr_lo = '0;
        raddr_lo = '0;
        fill     = '0;
        for (int c = 0; c < NR_OF_CH; c++) begin
            if (bus.wr_ch == CH_WIDTH'(c)) begin
                waddr_lo = wptr[c][ADDR_WIDTH-1:0];
                if (bus.wr_en && !bus.clr[c]) begin
                    wr_acc[c] = !full[c];
                    wr_rej[c] = full[c];
                end
            end
            if (bus.rd_ch == CH_WIDTH'(c)) begin
                raddr_lo = rptr[c][ADDR_WIDTH-1:0];
                if (bus.rd_en && !bus.clr[c]) begin
                    rd_acc[c] = !empty[c];
                    rd_rej[c] = empty[c];
                end
            end
            if (bus.stat_ch == CH_WIDTH'(c)) fill = cnt[c];
        end
    end

    // Strobes are combinational so the RAM samples them on the same edge that moves the pointers.
    assign bus.mem_we       = rst_n && (|wr_acc);
    assign bus.mem_re       = rst_n && (|rd_acc);
    assign bus.waddr        = {bus.wr_ch, waddr_lo};
    assign bus.raddr        = {bus.rd_ch, raddr_lo};
    assign bus.fifo_full    = full;
    assign bus.fifo_empty   = empty;
    assign bus.almost_full  = afull;
    assign bus.almost_empty = aempty;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
    assign bus.fill_level   = fill;

    // NOTE: the pointer arrays are a handful of flops, not RAM, so they take the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NR_OF_CH; c++) begin
                wptr[c] <= '0;
                rptr[c] <= '0;
            end
            ovf_q <= '0;
            udf_q <= '0;
        end else begin
            // NOTE: non-blocking updates keep every channel reading the pre-edge pointers.
            for (int c = 0; c < NR_OF_CH; c++) begin
                if (bus.clr[c]) begin
                    wptr[c]  <= '0;
                    rptr[c]  <= '0;
                    ovf_q[c] <= 1'b0;
                    udf_q[c] <= 1'b0;
                end else begin
                    if (wr_acc[c]) wptr[c]  <= wptr[c] + ONE;
                    if (rd_acc[c]) rptr[c]  <= rptr[c] + ONE;
                    if (wr_rej[c]) ovf_q[c] <= 1'b1;
                    if (rd_rej[c]) udf_q[c] <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_versatile_fifo_mc_ctrl.sv
// Directed bench for versatile_fifo_mc_ctrl: a channel model predicts RAM strobes
// (queued per step) and status flags after every clock edge.
module tb_versatile_fifo_mc_ctrl;
    localparam int AW = 4;
    localparam int NC = 4;
    localparam int CW = 2;
    localparam int D  = 16;

    typedef struct {
        logic       we;
        logic [5:0] waddr;
        logic       re;
        logic [5:0] raddr;
    } strobe_t;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    strobe_t    sb [$];
    int         m_cnt [NC];
    logic [4:0] m_wp  [NC];
    logic [4:0] m_rp  [NC];
    logic [3:0] m_ovf;
    logic [3:0] m_udf;
    int         stat_sel;

    versatile_fifo_mc_ctrl_if #(.ADDR_WIDTH(AW), .NR_OF_CH(NC), .CH_WIDTH(CW)) bus ();

    versatile_fifo_mc_ctrl #(
        .ADDR_WIDTH(AW), .NR_OF_CH(NC), .CH_WIDTH(CW), .AFULL_LEVEL(12), .AEMPTY_LEVEL(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_cnt[c] = 0;
            m_wp[c]  = '0;
            m_rp[c]  = '0;
        end
        m_ovf = '0;
        m_udf = '0;
    endtask

    task automatic set_stat(input int c);
        stat_sel    = c;
        bus.stat_ch = CW'(c);
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".full"},   32'(bus.fifo_full),    32'h0);
        check({tag, ".empty"},  32'(bus.fifo_empty),   32'hF);
        check({tag, ".afull"},  32'(bus.almost_full),  32'h0);
        check({tag, ".aempty"}, 32'(bus.almost_empty), 32'hF);
        check({tag, ".ovf"},    32'(bus.overflow),     32'h0);
        check({tag, ".udf"},    32'(bus.underflow),    32'h0);
        check({tag, ".fill"},   32'(bus.fill_level),   32'h0);
        check({tag, ".we"},     32'(bus.mem_we),       32'h0);
        check({tag, ".re"},     32'(bus.mem_re),       32'h0);
    endtask

    task automatic check_status(input string tag);
        logic [3:0] f, e, af, ae;
        for (int c = 0; c < NC; c++) begin
            f[c]  = (m_cnt[c] == D);
            e[c]  = (m_cnt[c] == 0);
            af[c] = (m_cnt[c] >= 12);
            ae[c] = (m_cnt[c] <= 2);
        end
        check({tag, ".full"},   32'(bus.fifo_full),    32'(f));
        check({tag, ".empty"},  32'(bus.fifo_empty),   32'(e));
        check({tag, ".afull"},  32'(bus.almost_full),  32'(af));
        check({tag, ".aempty"}, 32'(bus.almost_empty), 32'(ae));
        check({tag, ".ovf"},    32'(bus.overflow),     32'(m_ovf));
        check({tag, ".udf"},    32'(bus.underflow),    32'(m_udf));
        check({tag, ".fill"},   32'(bus.fill_level),   32'(m_cnt[stat_sel]));
    endtask

    // One clock of stimulus: drive at negedge, check strobes, advance model at posedge, check status.
    task automatic step(input logic wen, input logic [1:0] wch, input logic ren,
                        input logic [1:0] rch, input logic [3:0] clrv, input string tag);
        strobe_t e, o;
        logic    wv, rv, wacc, wrej, racc, rrej;
        @(negedge clk);
        bus.wr_en = wen;
        bus.wr_ch = wch;
        bus.rd_en = ren;
        bus.rd_ch = rch;
        bus.clr   = clrv;
        wv   = wen && !clrv[wch];
        rv   = ren && !clrv[rch];
        wacc = wv && (m_cnt[wch] != D);
        wrej = wv && (m_cnt[wch] == D);
        racc = rv && (m_cnt[rch] != 0);
        rrej = rv && (m_cnt[rch] == 0);
        e.we    = wacc;
        e.waddr = {wch, m_wp[wch][3:0]};
        e.re    = racc;
        e.raddr = {rch, m_rp[rch][3:0]};
        sb.push_back(e);
        #1;
        o = sb.pop_front();
        check({tag, ".mem_we"}, 32'(bus.mem_we), 32'(o.we));
        if (o.we) check({tag, ".waddr"}, 32'(bus.waddr), 32'(o.waddr));
        check({tag, ".mem_re"}, 32'(bus.mem_re), 32'(o.re));
        if (o.re) check({tag, ".raddr"}, 32'(bus.raddr), 32'(o.raddr));
        @(posedge clk);
        for (int c = 0; c < NC; c++) begin
            if (clrv[c]) begin
                m_cnt[c] = 0;
                m_wp[c]  = '0;
                m_rp[c]  = '0;
                m_ovf[c] = 1'b0;
                m_udf[c] = 1'b0;
            end
        end
        if (wacc) begin
            m_cnt[wch]++;
            m_wp[wch] = m_wp[wch] + 5'd1;
        end
        if (racc) begin
            m_cnt[rch]--;
            m_rp[rch] = m_rp[rch] + 5'd1;
        end
        if (wrej) m_ovf[wch] = 1'b1;
        if (rrej) m_udf[rch] = 1'b1;
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.clr   = '0;
        check_status(tag);
    endtask

    initial begin
        model_reset();
        rst_n     = 1'b0;
        bus.wr_en = 1'b1;
        bus.wr_ch = '0;
        bus.rd_en = 1'b1;
        bus.rd_ch = '0;
        bus.clr   = '0;
        set_stat(0);
        #12;
        check_reset("reset");
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        rst_n     = 1'b1;

        // Fill channel 0; the model tracks almost_empty/almost_full edges and waddr 0x00..0x0F.
        for (int i = 0; i < D; i++) step(1'b1, 2'd0, 1'b0, 2'd0, 4'b0000, $sformatf("fill%0d", i));
        check("fill.level16", 32'(bus.fill_level), 32'd16);
        check("fill.full0",   32'(bus.fifo_full[0]), 32'd1);

        // Overflow on full channel, then flush with a colliding write that must be dropped.
        step(1'b1, 2'd0, 1'b0, 2'd0, 4'b0000, "ovf");
        check("ovf.flag0", 32'(bus.overflow[0]), 32'd1);
        step(1'b1, 2'd0, 1'b0, 2'd0, 4'b0001, "flush");
        check("flush.empty0", 32'(bus.fifo_empty[0]), 32'd1);
        check("flush.ovf0",   32'(bus.overflow[0]), 32'd0);

        // Wrap-around on channel 2 at a steady count of 5.
        set_stat(2);
        for (int i = 0; i < 5; i++) step(1'b1, 2'd2, 1'b0, 2'd0, 4'b0000, $sformatf("pre%0d", i));
        for (int i = 0; i < 40; i++) step(1'b1, 2'd2, 1'b1, 2'd2, 4'b0000, $sformatf("wrap%0d", i));
        check("wrap.level5", 32'(bus.fill_level), 32'd5);

        // Same-channel collisions: full channel 0, empty channel 3.
        set_stat(0);
        for (int i = 0; i < D; i++) step(1'b1, 2'd0, 1'b0, 2'd0, 4'b0000, $sformatf("refill%0d", i));
        step(1'b1, 2'd0, 1'b1, 2'd0, 4'b0000, "simfull");
        check("simfull.level15", 32'(bus.fill_level), 32'd15);
        set_stat(3);
        step(1'b1, 2'd3, 1'b1, 2'd3, 4'b0000, "simempty");
        check("simempty.level1", 32'(bus.fill_level), 32'd1);
        check("simempty.udf3",   32'(bus.underflow[3]), 32'd1);

        // Channel independence: ch3 to 4 entries, then write ch1 while reading ch3.
        for (int i = 0; i < 3; i++) step(1'b1, 2'd3, 1'b0, 2'd0, 4'b0000, $sformatf("ch3fill%0d", i));
        step(1'b1, 2'd1, 1'b1, 2'd3, 4'b0000, "indep");
        check("indep.level3", 32'(bus.fill_level), 32'd3);
        set_stat(1);
        #1;
        check("indep.level1", 32'(bus.fill_level), 32'd1);

        // Asynchronous reset between edges with a live write request.
        @(posedge clk);
        #2;
        bus.wr_en = 1'b1;
        bus.wr_ch = 2'd1;
        rst_n     = 1'b0;
        #1;
        check_reset("midrst");
        model_reset();
        @(negedge clk);
        bus.wr_en = 1'b0;
        rst_n     = 1'b1;
        step(1'b1, 2'd1, 1'b0, 2'd0, 4'b0000, "postrst");
        check("postrst.level1", 32'(bus.fill_level), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
